// File: rtl/rd_data_checker_if.sv
// rd_data_checker_if: compare-descriptor handshake and AMM read-data bundle
interface rd_data_checker_if #(
  parameter int AMM_DATA_W  = 512,
  parameter int AMM_BURST_W = 11,
  parameter int CMP_ADDR_W  = 26
);
  localparam int ADDR_B_W = $clog2(AMM_DATA_W / 8);
  typedef struct packed {
    logic                   trans_type;
    logic                   data_mode;
    logic [7:0]             data_ptrn;
    logic [CMP_ADDR_W-1:0]  start_addr;
    logic [ADDR_B_W-1:0]    start_off;
    logic [ADDR_B_W-1:0]    end_off;
    logic [AMM_BURST_W-2:0] words_count;
  } cmp_struct_t;
  cmp_struct_t           cmp_struct;
  logic                  cmp_valid;
  logic                  cmp_ready;
  logic [AMM_DATA_W-1:0] readdata;
  logic                  readdatavalid;
  modport master (output cmp_struct, cmp_valid, readdata, readdatavalid, input cmp_ready);
  modport slave  (input cmp_struct, cmp_valid, readdata, readdatavalid, output cmp_ready);
endinterface

// File: rtl/rd_data_checker.sv
// rd_data_checker: checks AMM read bursts against descriptor patterns; CMP_ERR_CNT_EN adds a mismatched-byte counter
module rd_data_checker #(
  parameter int AMM_DATA_W  = 512,
  parameter int AMM_BURST_W = 11,
  parameter int CMP_ADDR_W  = 26,
  localparam int DATA_B_W   = AMM_DATA_W / 8,
  localparam int ADDR_B_W   = $clog2(DATA_B_W),
  localparam int WC_W       = AMM_BURST_W - 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         test_start,
  rd_data_checker_if.slave             cmp,
  output logic                         busy,
  output logic                         err,
  output logic [CMP_ADDR_W+ADDR_B_W-1:0] err_addr,
  output logic [7:0]                   err_data,
  output logic                         unexp,
`ifdef CMP_ERR_CNT_EN
  output logic [31:0]                  err_cnt,
`endif
  output logic [31:0]                  rd_words
);
  typedef enum logic {IDLE_S, CHECK_S} state_t;
  state_t                state;
  logic [WC_W-1:0]       word_idx, words_count;
  logic [7:0]            exp_byte;
  logic [CMP_ADDR_W-1:0] start_addr;
  logic [ADDR_B_W-1:0]   start_off, end_off, err_byte;
  logic                  rnd, beat, last_beat, accept_rd;
  logic [DATA_B_W-1:0]   mask, mis;
  function automatic logic [DATA_B_W-1:0] byteenable_ptrn(input logic first, input logic [ADDR_B_W-1:0] s_off,
                                                          input logic last, input logic [ADDR_B_W-1:0] e_off);
    for (int i = 0; i < DATA_B_W; i++)
      byteenable_ptrn[i] = (!first || ADDR_B_W'(i) >= s_off) && (!last || ADDR_B_W'(i) <= e_off);
  endfunction
  function automatic logic [DATA_B_W-1:0] check_vector(input logic [DATA_B_W-1:0] m, input logic [7:0] e,
                                                       input logic [AMM_DATA_W-1:0] d);
    for (int i = 0; i < DATA_B_W; i++) check_vector[i] = m[i] && (d[8*i +: 8] != e);
  endfunction
  function automatic logic [ADDR_B_W-1:0] err_byte_find(input logic [DATA_B_W-1:0] v);
    err_byte_find = '0;
    for (int i = DATA_B_W - 1; i >= 0; i--) if (v[i]) err_byte_find = ADDR_B_W'(i);
  endfunction
  function automatic logic [7:0] lfsr_step(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction
  // a new descriptor is taken when idle or on the final beat; never while a start pulse clears state
  assign cmp.cmp_ready = !test_start && (state == IDLE_S || last_beat);
  // per-beat byte mask and mismatch detection against the expected byte
  always_comb begin
    beat      = state == CHECK_S && cmp.readdatavalid;
    last_beat = beat && word_idx == words_count;
    accept_rd = cmp.cmp_valid && cmp.cmp_ready && cmp.cmp_struct.trans_type;
    mask      = byteenable_ptrn(word_idx == '0, start_off, word_idx == words_count, end_off);
    mis       = check_vector(mask, exp_byte, cmp.readdata);
    err_byte  = err_byte_find(mis);
  end
`ifdef CMP_ERR_CNT_EN
  logic [32:0] err_sum;
  // running total of mismatched bytes, saturating
  always_comb begin
    err_sum = {1'b0, err_cnt};
    for (int i = 0; i < DATA_B_W; i++) err_sum = err_sum + 33'(beat && mis[i]);
  end
  // mismatched-byte counter register
  always_ff @(posedge clk)
    if (rst || test_start) err_cnt <= '0;
    else err_cnt <= err_sum[32] ? '1 : err_sum[31:0];
`endif
  // burst FSM, pattern generator, error capture and word counter
  always_ff @(posedge clk) begin
    if (rst || test_start) begin
      state       <= IDLE_S;
      busy        <= 1'b0;
      err         <= 1'b0;
      err_addr    <= '0;
      err_data    <= '0;
      unexp       <= 1'b0;
      rd_words    <= '0;
      word_idx    <= '0;
      words_count <= '0;
      exp_byte    <= '0;
      start_addr  <= '0;
      start_off   <= '0;
      end_off     <= '0;
      rnd         <= 1'b0;
    end else begin
      if (state == IDLE_S && cmp.readdatavalid) unexp <= 1'b1;
      if (beat) begin
        word_idx <= word_idx + 1'b1;
        if (rnd) exp_byte <= lfsr_step(exp_byte);
        if (~&rd_words) rd_words <= rd_words + 32'd1;
        if (!err && |mis) begin
          err      <= 1'b1;
          err_addr <= {start_addr + CMP_ADDR_W'(word_idx), err_byte};
          err_data <= cmp.readdata[8*err_byte +: 8];
        end
      end
      if (last_beat) begin
        state <= IDLE_S;
        busy  <= 1'b0;
      end
      if (accept_rd) begin
        state       <= CHECK_S;
        busy        <= 1'b1;
        word_idx    <= '0;
        words_count <= cmp.cmp_struct.words_count;
        exp_byte    <= cmp.cmp_struct.data_ptrn;
        start_addr  <= cmp.cmp_struct.start_addr;
        start_off   <= cmp.cmp_struct.start_off;
        end_off     <= cmp.cmp_struct.end_off;
        rnd         <= cmp.cmp_struct.data_mode;
      end
    end
  end
endmodule

// File: tb/tb_rd_data_checker.sv
// tb_rd_data_checker: directed-vector bench for rd_data_checker
module tb_rd_data_checker;
  localparam int DW = 512, BW = 11, AW = 26;
  logic clk = 0, rst = 1, test_start = 0;
  logic busy, err, unexp;
  logic [AW+5:0] err_addr;
  logic [7:0] err_data;
  logic [31:0] rd_words;
`ifdef CMP_ERR_CNT_EN
  logic [31:0] err_cnt;
`endif
  logic [DW-1:0] d;
  int n_checks = 0, n_fail = 0;
  rd_data_checker_if #(.AMM_DATA_W(DW), .AMM_BURST_W(BW), .CMP_ADDR_W(AW)) bus ();
  rd_data_checker #(.AMM_DATA_W(DW), .AMM_BURST_W(BW), .CMP_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .test_start(test_start), .cmp(bus),
    .busy(busy), .err(err), .err_addr(err_addr), .err_data(err_data), .unexp(unexp),
`ifdef CMP_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .rd_words(rd_words)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_desc(input logic tt, input logic mode, input logic [7:0] p, input logic [AW-1:0] a,
                          input logic [5:0] so, input logic [5:0] eo, input logic [9:0] wc);
    bus.cmp_struct.trans_type  = tt;
    bus.cmp_struct.data_mode   = mode;
    bus.cmp_struct.data_ptrn   = p;
    bus.cmp_struct.start_addr  = a;
    bus.cmp_struct.start_off   = so;
    bus.cmp_struct.end_off     = eo;
    bus.cmp_struct.words_count = wc;
  endtask
  task automatic step(input logic vld, input logic rdv, input logic [DW-1:0] dat, input logic exp_rdy, input string tag);
    bus.cmp_valid = vld;
    bus.readdatavalid = rdv;
    bus.readdata = dat;
    #1;
    if (vld) check(tag, bus.cmp_ready, exp_rdy);
    @(negedge clk);
    bus.cmp_valid = 0;
    bus.readdatavalid = 0;
  endtask
  task automatic pulse_start();
    test_start = 1;
    @(negedge clk);
    test_start = 0;
  endtask
  function automatic logic [DW-1:0] fill(input logic [7:0] b);
    return {64{b}};
  endfunction
  initial begin
    bus.cmp_valid = 0;
    bus.readdatavalid = 0;
    bus.readdata = '0;
    set_desc(0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_err_addr", err_addr, 0);
    check("rst_unexp", unexp, 0);
    check("rst_rd_words", rd_words, 0);
    // clean FIX_DATA burst of four words
    set_desc(1, 0, 8'h5A, 26'h100, 0, 63, 3);
    step(1, 0, '0, 1, "s1_ready");
    check("s1_busy_start", busy, 1);
    repeat (3) step(0, 1, fill(8'h5A), 0, "");
    check("s1_busy_mid", busy, 1);
    step(0, 1, fill(8'h5A), 0, "");
    check("s1_busy_end", busy, 0);
    check("s1_err", err, 0);
    check("s1_rd_words", rd_words, 4);
    // error on word 2 byte 17, later error on word 3 ignored
    pulse_start();
    check("s2_cleared", rd_words, 0);
    step(1, 0, '0, 1, "s2_ready");
    step(0, 1, fill(8'h5A), 0, "");
    step(0, 1, fill(8'h5A), 0, "");
    check("s2_err_before", err, 0);
    d = fill(8'h5A);
    d[8*17 +: 8] = 8'h00;
    step(0, 1, d, 0, "");
    check("s2_err", err, 1);
    check("s2_err_addr", err_addr, {26'h102, 6'd17});
    check("s2_err_data", err_data, 8'h00);
    d = fill(8'h5A);
    d[8*5 +: 8] = 8'hEE;
    step(0, 1, d, 0, "");
    check("s2_addr_kept", err_addr, {26'h102, 6'd17});
    check("s2_data_kept", err_data, 8'h00);
    check("s2_rd_words", rd_words, 4);
    // single word with both offsets applied
    pulse_start();
    set_desc(1, 0, 8'h5A, 26'h20, 4, 9, 0);
    d = fill(8'h00);
    d[8*4 +: 48] = {6{8'h5A}};
    step(1, 0, '0, 1, "s3_ready");
    step(0, 1, d, 0, "");
    check("s3_err_masked", err, 0);
    check("s3_busy", busy, 0);
    check("s3_rd_words", rd_words, 1);
    d[8*9 +: 8] = 8'h33;
    step(1, 0, '0, 1, "s3_ready2");
    step(0, 1, d, 0, "");
    check("s3_err", err, 1);
    check("s3_err_addr", err_addr, {26'h20, 6'd9});
    check("s3_err_data", err_data, 8'h33);
    // LFSR pattern sequence 01, B8, 5C
    pulse_start();
    set_desc(1, 1, 8'h01, 26'h40, 0, 63, 2);
    step(1, 0, '0, 1, "s4_ready");
    step(0, 1, fill(8'h01), 0, "");
    step(0, 1, fill(8'hB8), 0, "");
    step(0, 1, fill(8'h5C), 0, "");
    check("s4_err", err, 0);
    check("s4_rd_words", rd_words, 3);
    set_desc(1, 1, 8'h01, 26'h50, 0, 63, 0);
    step(1, 0, '0, 1, "s4_ready2");
    step(0, 1, fill(8'hB8), 0, "");
    check("s4_err_w0", err, 1);
    check("s4_err_addr", err_addr, {26'h50, 6'd0});
    check("s4_err_data", err_data, 8'hB8);
    // back-to-back descriptors, unexpected beat, dropped write descriptor
    pulse_start();
    set_desc(1, 0, 8'h11, 26'h0, 0, 63, 1);
    step(1, 0, '0, 1, "s5_ready_a");
    set_desc(1, 0, 8'h22, 26'h8, 0, 63, 0);
    step(1, 1, fill(8'h11), 0, "s5_ready_mid");
    step(1, 1, fill(8'h11), 1, "s5_ready_last");
    check("s5_busy_b", busy, 1);
    step(0, 1, fill(8'h22), 0, "");
    check("s5_busy_end", busy, 0);
    check("s5_err", err, 0);
    check("s5_rd_words", rd_words, 3);
    step(0, 1, fill(8'h00), 0, "");
    check("s5_unexp", unexp, 1);
    check("s5_rd_words_idle", rd_words, 3);
    set_desc(0, 0, 8'h00, 26'h0, 0, 63, 3);
    step(1, 0, '0, 1, "s5_ready_wr");
    check("s5_wr_idle", busy, 0);
    check("s5_wr_words", rd_words, 3);
    // test_start mid-burst clears everything
    pulse_start();
    set_desc(1, 0, 8'h5A, 26'h0, 0, 63, 3);
    step(1, 0, '0, 1, "s6_ready");
    d = fill(8'h5A);
    d[8*1 +: 24] = 24'h0;
    step(0, 1, d, 0, "");
    check("s6_err", err, 1);
    check("s6_err_addr", err_addr, 32'd1);
`ifdef CMP_ERR_CNT_EN
    check("s6_err_cnt", err_cnt, 3);
`endif
    bus.readdatavalid = 1;
    bus.readdata = fill(8'h5A);
    test_start = 1;
    @(negedge clk);
    test_start = 0;
    bus.readdatavalid = 0;
    check("s6_busy_clr", busy, 0);
    check("s6_err_clr", err, 0);
    check("s6_addr_clr", err_addr, 0);
    check("s6_words_clr", rd_words, 0);
`ifdef CMP_ERR_CNT_EN
    check("s6_err_cnt_clr", err_cnt, 0);
`endif
    step(0, 1, fill(8'h5A), 0, "");
    check("s6_idle_unexp", unexp, 1);
    check("s6_idle_words", rd_words, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/rd_data_checker.md
Name: rd_data_checker

Overview:
- Read-data comparison stage of the memory checker, sitting downstream of the transaction generator and the AMM read port.
- Pops one compare descriptor (cmp_struct_t from rtl_settings_pkg) per issued transaction.
- Consumes the matching burst of AMM readdata beats and checks every enabled byte against the expected pattern.
- Latches the first mismatch (address and data) for the CSR block, and counts checked words.

Parameters:
AMM_DATA_W, 512, AMM data width in bits; DATA_B_W = AMM_DATA_W/8
AMM_BURST_W, 11, AMM burstcount width; words_count field is AMM_BURST_W-1 bits
CMP_ADDR_W, rtl_settings_pkg value, word-address width of start_addr
ADDR_B_W, $clog2(DATA_B_W), byte-offset width

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
test_start_i  in  1  one-cycle pulse; synchronous clear of all state/flags
cmp_struct_i  in  cmp_struct_t  compare descriptor
cmp_valid_i  in  1  descriptor valid
cmp_ready_o  out  1  descriptor accepted when valid&ready
readdata_i  in  AMM_DATA_W  AMM read data
readdatavalid_i  in  1  AMM read data valid
busy_o  out  1  burst in progress
err_o  out  1  sticky: mismatch found
err_addr_o  out  CMP_ADDR_W+ADDR_B_W  byte address of first mismatch
err_data_o  out  8  received byte at first mismatch
unexp_o  out  1  sticky: readdatavalid with no active descriptor
rd_words_o  out  32  checked-word count, saturating at 2^32-1

Behaviour:
- Reset / test_start_i: all outputs 0; FSM -> IDLE_S; LFSR and counters cleared. test_start_i has priority over all other events in the same cycle.
- Burst length: words_count+1 beats (1..2^(AMM_BURST_W-1)). Word index counter is AMM_BURST_W-1 bits.
- FSM IDLE_S:
  - cmp_ready_o=1.
  - On accept with trans_type=1 (read): latch descriptor, word_idx=0, exp_byte=data_ptrn, go CHECK_S.
  - On accept with trans_type=0: drop the descriptor, stay IDLE_S, no readdata consumed.
- FSM CHECK_S:
  - busy_o=1.
  - Each readdatavalid_i beat is checked.
  - Mask per beat: byteenable_ptrn(first, start_off, last, end_off), where first = (word_idx==0) and last = (word_idx==words_count). A single-word burst applies both offsets.
  - Mismatch vector: check_vector(mask, exp_byte, readdata_i).
  - After each beat: word_idx++; if data_mode=RND_DATA, exp_byte advances one step of Galois LFSR x^8+x^6+x^5+x^4+1 (taps 0xB8, shift right). FIX_DATA holds exp_byte.
  - Last beat: cmp_ready_o=1 combinationally in the same cycle, allowing back-to-back bursts with zero bubble. Accepting a read descriptor stays in CHECK_S with the new context; otherwise -> IDLE_S.
- Error capture:
  - First nonzero mismatch vector while err_o=0 latches err_addr_o = {start_addr+word_idx, err_byte_find(vector)} and err_data_o = that readdata byte.
  - err_o rises the cycle after the beat (1-cycle latency). Address addition wraps modulo 2^CMP_ADDR_W.
  - Later mismatches do not overwrite the capture. Checking and counting continue.
- rd_words_o increments by 1 per checked beat, registered, 1-cycle latency. trans_type=0 descriptors are not counted.
- readdatavalid_i in IDLE_S: beat discarded, unexp_o set (sticky), rd_words_o unchanged.
- cmp_valid_i held with ready low: descriptor must remain stable. The block never drops a presented descriptor.
- All outputs are registered except cmp_ready_o.

Optional Feature:
- Macro CMP_ERR_CNT_EN.
- When defined: adds output err_cnt_o [31:0], which adds the popcount of each beat's mismatch vector (bytes_count_func), saturating at 2^32-1, cleared by reset/test_start_i, 1-cycle latency.
- When undefined: port and logic absent; err_o capture behaviour unchanged.

Test Plan:
- FIX_DATA 0x5A, start_off=0, end_off=63, words_count=3, all bytes 0x5A -> err_o=0, rd_words_o=4, busy_o falls after beat 4.
- Same burst, beat 2 byte 17 = 0x00, start_addr=0x100 -> err_addr_o={0x102,17}, err_data_o=0x00, err_o high one cycle after beat 2; a later error on beat 3 leaves the capture unchanged.
- Single word, start_off=4, end_off=9, bytes 0..3 and 10..63 corrupted -> no error; corrupt byte 9 instead -> err_addr_o low bits=9.
- RND_DATA seed 0x01, 3 words -> expected bytes 0x01, 0xB8, 0x5C. Feeding 0xB8 on word 0 flags an error at word 0.
- Two descriptors presented back-to-back -> second accepted in the last-beat cycle of the first; no bubble, rd_words_o correct. readdatavalid_i in IDLE_S -> unexp_o=1.
- test_start_i mid-burst -> all flags/counters 0 and FSM in IDLE_S next cycle; with CMP_ERR_CNT_EN, 3 corrupted bytes in one beat -> err_cnt_o=3.
